// File: rtl/memory_forwarding_unit.sv
// Operand forwarding for store/out instructions: tracks in-flight destination writes,
// steers each data source to the youngest producer and requests a stall on load-use.
module memory_forwarding_unit #(
  parameter int DATA_SEL_W = 4,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  advance,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [7:0]            id_opcode,
  input  logic [REG_AW-1:0]     id_src_top,
  input  logic [REG_AW-1:0]     id_src_bot,
  input  logic [REG_AW-1:0]     id_src_sfr,
  input  logic                  iss_wr_en,
  input  logic [REG_AW-1:0]     iss_dest,
  input  logic                  iss_is_load,
  output logic [DATA_SEL_W-1:0] sel_top,
  output logic [DATA_SEL_W-1:0] sel_bot,
  output logic [DATA_SEL_W-1:0] sel_sfr,
  output logic                  hazard_stall,
  output logic [CNT_W-1:0]      hazard_count
);

  localparam int                    DEPTH    = DATA_SEL_W - 1;
  localparam int                    NSRC     = 3;
  localparam logic [7:0]            OP_STORE = 8'hC4;
  localparam logic [7:0]            OP_OUT   = 8'h9C;
  localparam logic [DATA_SEL_W-1:0] SEL_RF   = DATA_SEL_W'(1);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_is_load;
  logic [REG_AW-1:0] r_dest [DEPTH];
  logic [CNT_W-1:0]  r_count;

  logic                  w_is_store;
  logic                  w_is_out;
  logic [NSRC-1:0]       w_use;
  logic [REG_AW-1:0]     w_src     [NSRC];
  logic [DEPTH-1:0]      w_hit     [NSRC];
  logic [NSRC-1:0]       w_load_hit;
  logic [DATA_SEL_W-1:0] w_sel     [NSRC];

  assign w_is_store = id_valid && (id_opcode == OP_STORE);
  assign w_is_out   = id_valid && (id_opcode == OP_OUT);

  // Index 0 = top, 1 = bot, 2 = sfr; out only consumes the SFR operand.
  assign w_src[0] = id_src_top;
  assign w_src[1] = id_src_bot;
  assign w_src[2] = id_src_sfr;
  assign w_use    = {w_is_store | w_is_out, w_is_store, w_is_store};

  genvar gi, gk;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      for (gk = 0; gk < DEPTH; gk++) begin : g_slot
        assign w_hit[gi][gk] = w_use[gi] && (w_src[gi] != '0) && r_valid[gk]
                               && (r_dest[gk] == w_src[gi]);
      end
      assign w_load_hit[gi] = w_hit[gi][0] && r_is_load[0];
    end
  endgenerate

  assign hazard_stall = |w_load_hit;

  // Scan oldest to youngest so the youngest matching slot wins.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      w_sel[i] = SEL_RF;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (w_hit[i][k]) w_sel[i] = SEL_RF << (k + 1);
      end
      if (hazard_stall) w_sel[i] = SEL_RF;
    end
  end

  assign sel_top      = w_sel[0];
  assign sel_bot      = w_sel[1];
  assign sel_sfr      = w_sel[2];
  assign hazard_count = r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= '0;
      r_is_load <= '0;
      for (int k = 0; k < DEPTH; k++) r_dest[k] <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (advance) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        r_valid[k]   <= r_valid[k-1];
        r_is_load[k] <= r_is_load[k-1];
        r_dest[k]    <= r_dest[k-1];
      end
      // A stalled decode lets the older entries drain and inserts a bubble.
      r_valid[0]   <= !hazard_stall && iss_wr_en && (iss_dest != '0);
      r_is_load[0] <= iss_is_load;
      r_dest[0]    <= iss_dest;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (hazard_stall && advance && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_memory_forwarding_unit.sv
// Randomised and directed bench for memory_forwarding_unit against a slot-list reference model.
module tb_memory_forwarding_unit;
  localparam int SW    = 4;
  localparam int AW    = 5;
  localparam int CW    = 6;
  localparam int DEPTH = SW - 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          advance = 1'b0;
  logic          flush = 1'b0;
  logic          id_valid = 1'b0;
  logic [7:0]    id_opcode = 8'h00;
  logic [AW-1:0] id_src_top = '0;
  logic [AW-1:0] id_src_bot = '0;
  logic [AW-1:0] id_src_sfr = '0;
  logic          iss_wr_en = 1'b0;
  logic [AW-1:0] iss_dest = '0;
  logic          iss_is_load = 1'b0;
  logic [SW-1:0] sel_top, sel_bot, sel_sfr;
  logic          hazard_stall;
  logic [CW-1:0] hazard_count;

  memory_forwarding_unit #(.DATA_SEL_W(SW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .advance(advance), .flush(flush),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_src_top(id_src_top), .id_src_bot(id_src_bot), .id_src_sfr(id_src_sfr),
    .iss_wr_en(iss_wr_en), .iss_dest(iss_dest), .iss_is_load(iss_is_load),
    .sel_top(sel_top), .sel_bot(sel_bot), .sel_sfr(sel_sfr),
    .hazard_stall(hazard_stall), .hazard_count(hazard_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: list of in-flight writes, index 0 youngest.
  int m_valid [DEPTH];
  int m_dest  [DEPTH];
  int m_load  [DEPTH];
  int m_count;
  int e_top, e_bot, e_sfr, e_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_sel(int src, bit used);
    if (!used || src == 0) return 1;
    for (int k = 0; k < DEPTH; k++)
      if (m_valid[k] != 0 && m_dest[k] == src) return 1 << (k + 1);
    return 1;
  endfunction

  function automatic bit model_luse(int src, bit used);
    return used && src != 0 && m_valid[0] != 0 && m_load[0] != 0 && m_dest[0] == src;
  endfunction

  task automatic model_eval();
    bit any_op, st_op;
    any_op  = id_valid && (id_opcode == 8'hC4 || id_opcode == 8'h9C);
    st_op   = id_valid && (id_opcode == 8'hC4);
    e_stall = (model_luse(int'(id_src_top), st_op) || model_luse(int'(id_src_bot), st_op)
               || model_luse(int'(id_src_sfr), any_op)) ? 1 : 0;
    e_top = e_stall ? 1 : model_sel(int'(id_src_top), st_op);
    e_bot = e_stall ? 1 : model_sel(int'(id_src_bot), st_op);
    e_sfr = e_stall ? 1 : model_sel(int'(id_src_sfr), any_op);
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_valid[k] = 0; m_dest[k] = 0; m_load[k] = 0;
    end
    m_count = 0;
  endtask

  task automatic sample();
    @(negedge clock);
    model_eval();
    chk("sel_top", 32'(sel_top), 32'(e_top));
    chk("sel_bot", 32'(sel_bot), 32'(e_bot));
    chk("sel_sfr", 32'(sel_sfr), 32'(e_sfr));
    chk("stall", 32'(hazard_stall), 32'(e_stall));
    chk("count", 32'(hazard_count), 32'(m_count));
    chk("onehot", 32'({$onehot(sel_top), $onehot(sel_bot), $onehot(sel_sfr)}), 32'h7);
  endtask

  task automatic edge_step();
    @(posedge clock);
    if (e_stall != 0 && advance && m_count < CMAX) m_count++;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) m_valid[k] = 0;
    end else if (advance) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        m_valid[k] = m_valid[k-1]; m_dest[k] = m_dest[k-1]; m_load[k] = m_load[k-1];
      end
      m_valid[0] = (e_stall == 0 && iss_wr_en && iss_dest != 0) ? 1 : 0;
      m_dest[0]  = int'(iss_dest);
      m_load[0]  = int'(iss_is_load);
    end
    #1;
  endtask

  task automatic set_id(input logic [7:0] op, input int top, input int bot, input int sfr);
    id_valid = 1'b1; id_opcode = op;
    id_src_top = AW'(top); id_src_bot = AW'(bot); id_src_sfr = AW'(sfr);
  endtask

  task automatic push(input int dest, input bit ld);
    id_valid = 1'b0; flush = 1'b0; advance = 1'b1;
    iss_wr_en = 1'b1; iss_dest = AW'(dest); iss_is_load = ld;
    sample(); edge_step();
    iss_wr_en = 1'b0;
  endtask

  task automatic hold_id();
    advance = 1'b0; flush = 1'b0; iss_wr_en = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_sel_top", 32'(sel_top), 32'h1);
    chk("rst_sel_sfr", 32'(sel_sfr), 32'h1);
    chk("rst_stall", 32'(hazard_stall), 32'h0);
    chk("rst_count", 32'(hazard_count), 32'h0);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Slot1 holds an ALU write to r3.
    push(3, 0); push(0, 0);
    set_id(8'hC4, 3, 0, 0); hold_id();
    sample();
    chk("ex_slot1_top", 32'(sel_top), 32'h4);
    chk("ex_slot1_bot", 32'(sel_bot), 32'h1);
    edge_step();

    // r7 in slot0 and slot2: youngest wins.
    push(7, 0); push(2, 0); push(7, 0);
    set_id(8'hC4, 0, 7, 0); hold_id();
    sample();
    chk("ex_youngest_bot", 32'(sel_bot), 32'h2);
    edge_step();

    // Out forwards SFR only; source 0 stays on the register file.
    push(9, 0);
    set_id(8'h9C, 9, 0, 9); hold_id();
    sample();
    chk("ex_out_sfr", 32'(sel_sfr), 32'h2);
    chk("ex_out_top", 32'(sel_top), 32'h1);
    chk("ex_out_bot0", 32'(sel_bot), 32'h1);
    edge_step();

    // Flush over a full history.
    set_id(8'hC4, 9, 7, 2); flush = 1'b1; advance = 1'b1;
    sample(); edge_step();
    hold_id();
    sample();
    chk("ex_flush_top", 32'(sel_top), 32'h1);
    chk("ex_flush_bot", 32'(sel_bot), 32'h1);
    chk("ex_flush_sfr", 32'(sel_sfr), 32'h1);
    edge_step();

    // Load-use: one stall cycle, bubble, then forward from slot1.
    push(5, 1);
    set_id(8'hC4, 5, 0, 0); advance = 1'b1; iss_wr_en = 1'b1; iss_dest = AW'(6);
    sample();
    chk("ex_luse_stall", 32'(hazard_stall), 32'h1);
    chk("ex_luse_top", 32'(sel_top), 32'h1);
    edge_step();
    sample();
    chk("ex_luse_after_stall", 32'(hazard_stall), 32'h0);
    chk("ex_luse_after_top", 32'(sel_top), 32'h4);
    chk("ex_luse_count", 32'(hazard_count), 32'h1);
    edge_step();

    // Saturate the hazard counter.
    for (int n = 0; n < (1 << CW) + 3; n++) begin
      push(5, 1);
      set_id(8'hC4, 5, 0, 0); advance = 1'b1; iss_wr_en = 1'b0;
      sample(); edge_step();
    end
    hold_id(); id_valid = 1'b0;
    sample();
    chk("ex_count_sat", 32'(hazard_count), 32'(CMAX));
    edge_step();

    // Asynchronous reset in the middle of a stall.
    push(5, 1);
    set_id(8'hC4, 5, 0, 0); advance = 1'b1;
    @(negedge clock);
    chk("pre_reset_stall", 32'(hazard_stall), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_stall", 32'(hazard_stall), 32'h0);
    chk("async_rst_count", 32'(hazard_count), 32'h0);
    chk("async_rst_top", 32'(sel_top), 32'h1);
    @(posedge clock);
    #2 reset_n = 1'b1;
    model_reset();
    sample(); edge_step();

    for (int n = 0; n < 600; n++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0, 1:    id_opcode = 8'hC4;
        2:       id_opcode = 8'h9C;
        default: id_opcode = 8'($urandom);
      endcase
      id_src_top  = AW'($urandom_range(0, 7));
      id_src_bot  = AW'($urandom_range(0, 7));
      id_src_sfr  = AW'($urandom_range(0, 7));
      advance     = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      iss_wr_en   = ($urandom_range(0, 3) != 0);
      iss_dest    = AW'($urandom_range(0, 7));
      iss_is_load = ($urandom_range(0, 3) == 0);
      sample(); edge_step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_forwarding_unit.md
MEMORY_FORWARDING_UNIT -- requirements
Module: memory_forwarding_unit

Interface
REQ-001 The block SHALL have parameter DATA_SEL_W, default 4, giving the width of each one-hot select (bit0 = register file, bit k = pipeline slot k-1); legal range 2..5.
REQ-002 The block SHALL have parameter REG_AW, default 5, giving the register address width; register 0 reads as zero and is never forwarded.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the hazard counter.
REQ-004 The block SHALL derive DEPTH = DATA_SEL_W-1 as the number of tracked in-flight slots.
REQ-005 Port: clock  in  1  rising-edge clock.
REQ-006 Port: reset_n  in  1  asynchronous active-low reset.
REQ-007 Port: advance  in  1  pipeline moves one stage this cycle.
REQ-008 Port: flush  in  1  discards all in-flight entries.
REQ-009 Port: id_valid  in  1  the decode-stage instruction is real.
REQ-010 Port: id_opcode  in  8  decode opcode (8'hC4 store/store-FB/push; 8'h9C out).
REQ-011 Port: id_src_top, id_src_bot, id_src_sfr  in  REG_AW each  source registers for the write-data high byte, low byte, and SFR data.
REQ-012 Port: iss_wr_en, iss_dest, iss_is_load  in  1/REG_AW/1  destination write of the instruction entering slot 0.
REQ-013 Port: sel_top, sel_bot, sel_sfr  out  DATA_SEL_W each  one-hot forwarding selects.
REQ-014 Port: hazard_stall  out  1  load-use stall request.
REQ-015 Port: hazard_count  out  CNT_W  count of stall cycles since reset.

Function
REQ-016 The block SHALL hold history slots 0..DEPTH-1, each {valid, dest, is_load}; slot 0 is the youngest.
REQ-017 On a clock edge with advance=1 and hazard_stall=0, slot k SHALL take slot k-1 and slot 0 SHALL take {iss_wr_en & (iss_dest!=0), iss_dest, iss_is_load}.
REQ-018 On a clock edge with advance=1 and hazard_stall=1, slots 1..DEPTH-1 SHALL shift and slot 0 SHALL load an invalid bubble.
REQ-019 On a clock edge with advance=0, history SHALL hold.
REQ-020 flush=1 SHALL clear every valid bit on the next edge and take priority over advance.
REQ-021 For each source, the select SHALL be combinational: bit k+1 for the youngest valid slot k whose dest equals the source, otherwise bit0.
REQ-022 Selects SHALL be bit0 when the source is 0, when id_valid=0, or when the opcode is neither 8'hC4 nor 8'h9C.
REQ-023 For 8'h9C, only sel_sfr SHALL forward; sel_top and sel_bot SHALL be bit0.
REQ-024 hazard_stall SHALL be 1 when id_valid=1, the opcode is 8'hC4 or 8'h9C, and any used source matches valid slot 0 with is_load=1.
REQ-025 While hazard_stall=1, all selects SHALL be bit0.
REQ-026 hazard_count SHALL increment on each edge where hazard_stall=1 and advance=1, and SHALL saturate at all-ones.
REQ-027 Every select output SHALL be exactly one-hot in all cycles.

Reset
REQ-028 reset_n=0 SHALL immediately clear all slots, with hazard_count=0, hazard_stall=0, and all selects equal to bit0, independent of clock.
REQ-029 Reset asserted mid-stall SHALL drop hazard_stall in the same cycle, and the first post-reset edge SHALL behave as from an empty history.

Verification
REQ-030 Store C4 with top=3; slot1 holds dest 3 (ALU) -> sel_top=4'b0100, sel_bot=4'b0001, hazard_stall=0.
REQ-031 Slot0 and slot2 both hold dest 7; store with bot=7 -> sel_bot=4'b0010 (youngest wins).
REQ-032 Slot0 holds a load to dest 5; store with top=5, advance=1 -> hazard_stall=1 for 1 cycle, bubble inserted, next cycle sel_top=4'b0100, hazard_count=1.
REQ-033 Out 9C with sfr=9 and top=9 while slot0 holds dest 9 (ALU) -> sel_sfr=4'b0010, sel_top=4'b0001; src 0 with slot dest 0 -> bit0.
REQ-034 Fill history, assert flush -> next cycle all selects equal bit0; reset_n pulsed low mid-stall -> hazard_stall=0 asynchronously.
REQ-035 Force 2^CNT_W+3 stall cycles -> hazard_count holds all-ones.
